signed_clamp_rr_scheduler: RTL and testbench

Shares one signed saturation (clamp) datapath between `NUM_CH` requester channels using round-robin arbitration with valid/ready handshakes. Each accepted sample is narrowed from `IN_WIDTH` to `OUT_WIDTH` with saturation and registered into a single output stage, tagged with its source channel and a saturation flag. The block sits between parallel accumulator outputs and a shared narrow-precision write-back or cast path. It also keeps a saturation-event counter for quantisation monitoring.

---
 rtl/signed_clamp_rr_scheduler.sv | 117 +++++++++++
 tb/tb_signed_clamp_rr_scheduler.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/signed_clamp_rr_scheduler.sv
// Round-robin shared signed clamp: NUM_CH requesters feed one saturating narrower
// with a single registered output stage and a sticky saturation-event counter.
module signed_clamp_rr_scheduler #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 8,
    parameter int SYMMETRIC = 0,
    parameter int NUM_CH    = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_CH-1:0][IN_WIDTH-1:0]     data_in,
    input  logic [NUM_CH-1:0]                   data_in_valid,
    output logic [NUM_CH-1:0]                   data_in_ready,
    output logic [OUT_WIDTH-1:0]                data_out,
    output logic                                data_out_valid,
    input  logic                                data_out_ready,
    output logic [$clog2(NUM_CH)-1:0]           data_out_ch,
    output logic                                data_out_sat,
    input  logic                                clear_count,
    output logic [CNT_WIDTH-1:0]                sat_count
);

    localparam int CH_W = $clog2(NUM_CH);

    // Clamp limits, sign-extended to the input width so compares are signed at IN_WIDTH.
    localparam logic signed [IN_WIDTH-1:0] MAX_V = IN_WIDTH'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam logic signed [IN_WIDTH-1:0] MIN_V = IN_WIDTH'(SYMMETRIC - (2 ** (OUT_WIDTH - 1)));
    localparam logic [CH_W-1:0]            LAST_CH_RST = CH_W'(NUM_CH - 1);
    localparam logic [CNT_WIDTH-1:0]       CNT_MAX = '1;

    logic [CH_W-1:0]              last_ch;
    logic [CH_W-1:0]              grant;
    logic [CH_W-1:0]              cand;
    logic                         found;
    logic                         any_valid;
    logic                         load;
    logic                         transfer;
    int                           idx;

    logic signed [IN_WIDTH-1:0]   sample;
    logic [OUT_WIDTH-1:0]         clamp_val;
    logic                         clamp_sat;

    assign any_valid = |data_in_valid;
    assign load      = !data_out_valid || data_out_ready;
    assign transfer  = rst_n && load && any_valid;

    // Search starts one past the last grant and wraps, giving rotating priority.
    always_comb begin
        grant = last_ch;
        cand  = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = int'(last_ch) + i;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            cand = CH_W'(idx);
            if (!found && data_in_valid[cand]) begin
                grant = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        data_in_ready = '0;
        for (int g = 0; g < NUM_CH; g++) begin
            data_in_ready[g] = transfer && (grant == CH_W'(g));
        end
    end

    always_comb begin
        sample    = $signed(data_in[grant]);
        clamp_val = sample[OUT_WIDTH-1:0];
        clamp_sat = 1'b0;
        if (sample > MAX_V) begin
            clamp_val = MAX_V[OUT_WIDTH-1:0];
            clamp_sat = 1'b1;
        end else if (sample < MIN_V) begin
            clamp_val = MIN_V[OUT_WIDTH-1:0];
            clamp_sat = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_ch        <= LAST_CH_RST;
            data_out       <= '0;
            data_out_ch    <= '0;
            data_out_sat   <= 1'b0;
            data_out_valid <= 1'b0;
        end else if (transfer) begin
            last_ch        <= grant;
            data_out       <= clamp_val;
            data_out_ch    <= grant;
            data_out_sat   <= clamp_sat;
            data_out_valid <= 1'b1;
        end else if (data_out_ready) begin
            data_out_valid <= 1'b0;
        end
    end

    // Clear wins over a same-cycle saturated transfer; the count sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count <= '0;
        end else if (clear_count) begin
            sat_count <= '0;
        end else if (transfer && clamp_sat && (sat_count != CNT_MAX)) begin
            sat_count <= sat_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_signed_clamp_rr_scheduler.sv
// Directed bench: a default instance and a symmetric/2-bit-counter instance share stimulus.
module tb_signed_clamp_rr_scheduler;

    logic              clk;
    logic              rst_n;
    logic [3:0][15:0]  data_in;
    logic [3:0]        data_in_valid;
    logic              data_out_ready;
    logic              clear_count;

    logic [3:0]        a_ready, b_ready;
    logic [7:0]        a_data, b_data;
    logic              a_valid, b_valid;
    logic [1:0]        a_ch, b_ch;
    logic              a_sat, b_sat;
    logic [15:0]       a_count;
    logic [1:0]        b_count;

    int n_vec = 0;
    int n_err = 0;
    int g;

    signed_clamp_rr_scheduler dut_a (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_in_valid(data_in_valid),
        .data_in_ready(a_ready), .data_out(a_data), .data_out_valid(a_valid),
        .data_out_ready(data_out_ready), .data_out_ch(a_ch), .data_out_sat(a_sat),
        .clear_count(clear_count), .sat_count(a_count)
    );

    signed_clamp_rr_scheduler #(.SYMMETRIC(1), .CNT_WIDTH(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_in_valid(data_in_valid),
        .data_in_ready(b_ready), .data_out(b_data), .data_out_valid(b_valid),
        .data_out_ready(data_out_ready), .data_out_ch(b_ch), .data_out_sat(b_sat),
        .clear_count(clear_count), .sat_count(b_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n          = 1'b0;
        data_in        = '0;
        data_in_valid  = 4'hF;
        data_out_ready = 1'b0;
        clear_count    = 1'b0;
        #2;
        chk("rst_ready_a", 32'(a_ready), 32'h0);
        chk("rst_ready_b", 32'(b_ready), 32'h0);
        chk("rst_valid",   32'(a_valid), 32'h0);
        chk("rst_data",    32'(a_data),  32'h0);
        chk("rst_count",   32'(a_count), 32'h0);
        data_in_valid = 4'h0;
        #10 rst_n = 1'b1;
        tick();

        // Clamp values on channel 0
        data_out_ready = 1'b1;
        data_in[0]     = 16'd300;
        data_in_valid  = 4'b0001;
        #1;
        chk("clamp_ready_a", 32'(a_ready), 32'h1);
        chk("clamp_ready_b", 32'(b_ready), 32'h1);
        tick();
        chk("p300_data_a", 32'(a_data), 32'h7F);
        chk("p300_sat_a",  32'(a_sat),  32'h1);
        chk("p300_ch_a",   32'(a_ch),   32'h0);
        chk("p300_valid",  32'(a_valid), 32'h1);
        chk("p300_data_b", 32'(b_data), 32'h7F);
        chk("p300_cnt_a",  32'(a_count), 32'd1);
        data_in[0] = 16'(-300);
        tick();
        chk("m300_data_a", 32'(a_data), 32'h80);
        chk("m300_sat_a",  32'(a_sat),  32'h1);
        chk("m300_data_b", 32'(b_data), 32'h81);
        chk("m300_sat_b",  32'(b_sat),  32'h1);
        data_in[0] = 16'd100;
        tick();
        chk("p100_data_a", 32'(a_data), 32'h64);
        chk("p100_sat_a",  32'(a_sat),  32'h0);
        chk("p100_data_b", 32'(b_data), 32'h64);
        chk("p100_cnt_a",  32'(a_count), 32'd2);
        data_in[0] = 16'(-128);
        tick();
        chk("m128_data_a", 32'(a_data), 32'h80);
        chk("m128_sat_a",  32'(a_sat),  32'h0);
        chk("m128_data_b", 32'(b_data), 32'h81);
        chk("m128_sat_b",  32'(b_sat),  32'h1);
        chk("m128_cnt_a",  32'(a_count), 32'd2);
        chk("m128_cnt_b",  32'(b_count), 32'd3);
        data_in_valid = 4'b0000;
        tick();
        chk("drain_valid", 32'(a_valid), 32'h0);

        // Saturation counter, sticky at max on the 2-bit instance
        clear_count = 1'b1;
        tick();
        chk("clr_cnt_a", 32'(a_count), 32'd0);
        chk("clr_cnt_b", 32'(b_count), 32'd0);
        clear_count   = 1'b0;
        data_in[0]    = 16'd300;
        data_in_valid = 4'b0001;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("cnt_a", 32'(a_count), 32'(k));
            chk("cnt_b", 32'(b_count), (k > 3) ? 32'd3 : 32'(k));
        end
        clear_count = 1'b1;
        tick();
        chk("clr_pri_a",   32'(a_count), 32'd0);
        chk("clr_pri_b",   32'(b_count), 32'd0);
        chk("clr_pri_sat", 32'(a_sat),   32'h1);
        clear_count   = 1'b0;
        data_in_valid = 4'b0000;
        tick();

        // Round robin, last grant was channel 0
        data_in[0] = 16'd10;
        data_in[1] = 16'd20;
        data_in[2] = 16'd30;
        data_in[3] = 16'd40;
        data_in_valid = 4'hF;
        for (int k = 0; k < 6; k++) begin
            g = (1 + k) % 4;
            #1;
            chk("rr_ready", 32'(a_ready), 32'(1 << g));
            tick();
            chk("rr_ch_a",   32'(a_ch),   32'(g));
            chk("rr_data_a", 32'(a_data), 32'(10 * (g + 1)));
            chk("rr_ch_b",   32'(b_ch),   32'(g));
        end
        data_in_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            g = (k % 2 == 0) ? 3 : 1;
            #1;
            chk("rr13_ready", 32'(a_ready), 32'(1 << g));
            tick();
            chk("rr13_ch", 32'(a_ch), 32'(g));
        end

        // Backpressure with 127/ch2 held
        data_in[2]    = 16'd300;
        data_in_valid = 4'b0100;
        tick();
        chk("bp_load_data", 32'(a_data), 32'h7F);
        chk("bp_load_ch",   32'(a_ch),   32'h2);
        data_out_ready = 1'b0;
        data_in_valid  = 4'hF;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_ready_a", 32'(a_ready), 32'h0);
            tick();
            chk("bp_hold_data",  32'(a_data),  32'h7F);
            chk("bp_hold_ch",    32'(a_ch),    32'h2);
            chk("bp_hold_valid", 32'(a_valid), 32'h1);
            chk("bp_hold_sat",   32'(a_sat),   32'h1);
        end
        data_out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(a_ready), 32'h8);
        tick();
        chk("bp_next_ch",    32'(a_ch),    32'h3);
        chk("bp_next_data",  32'(a_data),  32'h28);
        chk("bp_next_valid", 32'(a_valid), 32'h1);

        // Asynchronous reset mid-operation with last grant on channel 2
        data_in_valid = 4'b0100;
        tick();
        chk("pre_rst_ch", 32'(a_ch), 32'h2);
        #3;
        rst_n         = 1'b0;
        data_in_valid = 4'hF;
        #1;
        chk("arst_valid", 32'(a_valid), 32'h0);
        chk("arst_data",  32'(a_data),  32'h0);
        chk("arst_ch",    32'(a_ch),    32'h0);
        chk("arst_sat",   32'(a_sat),   32'h0);
        chk("arst_count", 32'(a_count), 32'h0);
        chk("arst_ready", 32'(a_ready), 32'h0);
        #2;
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 32'(a_ready), 32'h1);
        tick();
        chk("post_rst_ch",    32'(a_ch),    32'h0);
        chk("post_rst_data",  32'(a_data),  32'h0A);
        chk("post_rst_valid", 32'(a_valid), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
